// File: rtl/chnl_pkg.sv
// rtl/chnl_pkg.sv - shared state type, dword width and beat-size helpers for the RX BRAM writer
package chnl_pkg;

  localparam int DWORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int dw_per_beat(input int data_w);
    return data_w / DWORD_W;
  endfunction

  // 33-bit so a LEN of 2^32-1 dwords still rounds up without wrapping
  function automatic logic [32:0] beats_for_len(input logic [31:0] len, input int dw);
    return ({1'b0, len} + 33'(dw - 1)) / 33'(dw);
  endfunction

endpackage

// File: rtl/chnl_beat_counter.sv
// rtl/chnl_beat_counter.sv - accepted-beat counter with end-of-transfer and BRAM-depth compares
module chnl_beat_counter #(
  parameter int C_DEPTH  = 1024,
  parameter int C_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic [32:0]         exp_beats,
  output logic [C_ADDR_W-1:0] wr_addr,
  output logic                in_range,
  output logic                last_beat,
  output logic                overflow,
  output logic [C_ADDR_W:0]   beats
);

  localparam logic [32:0] DEPTH33 = 33'(C_DEPTH);

  logic [32:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  assign in_range  = (cnt_q < DEPTH33);
  assign last_beat = inc && ((cnt_q + 33'd1) == exp_beats);
  assign overflow  = ovf_q;
  assign wr_addr   = cnt_q[C_ADDR_W-1:0];
  assign beats     = in_range ? cnt_q[C_ADDR_W:0] : (C_ADDR_W+1)'(C_DEPTH);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      cnt_d = cnt_q + 33'd1;
      if (!in_range) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/chnl_rx_bram_writer.sv
// rtl/chnl_rx_bram_writer.sv - RIFFA RX channel to BRAM buffer writer; RX_CHECKSUM_EN adds XFER_CHECKSUM
module chnl_rx_bram_writer
  import chnl_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_DEPTH          = 1024,
  parameter int C_ADDR_W         = 10
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  output logic                        BRAM_WE,
  output logic [C_ADDR_W-1:0]         BRAM_ADDR,
  output logic [C_PCI_DATA_WIDTH-1:0] BRAM_WDATA,
  output logic                        XFER_DONE,
  output logic [C_ADDR_W:0]           XFER_BEATS,
  output logic                        XFER_LAST,
  output logic                        XFER_OVERFLOW,
  input  logic                        XFER_ACK
`ifdef RX_CHECKSUM_EN
  ,
  output logic [31:0]                 XFER_CHECKSUM
`endif
);

  localparam int DW_PER_BEAT = dw_per_beat(C_PCI_DATA_WIDTH);

  state_e                      state_q, state_d;
  logic                        ack_q, ack_d;
  logic                        ren_q, ren_d;
  logic                        we_q, we_d;
  logic [C_ADDR_W-1:0]         addr_q, addr_d;
  logic [C_PCI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                        done_q, done_d;
  logic [C_ADDR_W:0]           beats_q, beats_d;
  logic                        xlast_q, xlast_d;
  logic                        xovf_q, xovf_d;
  logic [32:0]                 exp_q, exp_d;
  logic                        rx_last_q, rx_last_d;
  logic [31:0]                 csum_q, csum_d;
  logic [31:0]                 beat_fold;

  logic                        accept;
  logic                        cnt_clr;
  logic [C_ADDR_W-1:0]         cnt_addr;
  logic                        cnt_in_range;
  logic                        cnt_last;
  logic                        cnt_ovf;
  logic [C_ADDR_W:0]           cnt_beats;
  logic [32:0]                 len_beats;
  logic                        unused_off;

  assign unused_off = ^CHNL_RX_OFF;
  assign accept     = (state_q == RECV) && ren_q && CHNL_RX_DATA_VALID;
  assign len_beats  = beats_for_len(CHNL_RX_LEN, DW_PER_BEAT);

  chnl_beat_counter #(
    .C_DEPTH  (C_DEPTH),
    .C_ADDR_W (C_ADDR_W)
  ) u_cnt (
    .clk       (CLK),
    .rst       (RST),
    .clr       (cnt_clr),
    .inc       (accept),
    .exp_beats (exp_q),
    .wr_addr   (cnt_addr),
    .in_range  (cnt_in_range),
    .last_beat (cnt_last),
    .overflow  (cnt_ovf),
    .beats     (cnt_beats)
  );

  always_comb begin
    beat_fold = '0;
    for (int i = 0; i < DW_PER_BEAT; i++) begin
      beat_fold = beat_fold ^ CHNL_RX_DATA[i*DWORD_W +: DWORD_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    ren_d     = ren_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    beats_d   = beats_q;
    xlast_d   = xlast_q;
    xovf_d    = xovf_q;
    exp_d     = exp_q;
    rx_last_d = rx_last_q;
    csum_d    = csum_q;
    cnt_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (CHNL_RX) begin
          exp_d     = len_beats;
          rx_last_d = CHNL_RX_LAST;
          ack_d     = 1'b1;
          cnt_clr   = 1'b1;
          csum_d    = '0;
          if (len_beats == 33'd0) begin
            state_d = DONE;
            ren_d   = 1'b0;
          end else begin
            state_d = RECV;
            ren_d   = 1'b1;
          end
        end
      end

      RECV: begin
        if (accept) begin
          // Beats past the BRAM depth are drained from the host but dropped here
          if (cnt_in_range) begin
            we_d    = 1'b1;
            addr_d  = cnt_addr;
            wdata_d = CHNL_RX_DATA;
            csum_d  = csum_q ^ beat_fold;
          end
          if (cnt_last) begin
            state_d = DONE;
            ren_d   = 1'b0;
          end
        end else if (!CHNL_RX && !CHNL_RX_DATA_VALID) begin
          state_d = DONE;
          ren_d   = 1'b0;
        end
      end

      DONE: begin
        // First DONE cycle lets the final BRAM write retire before XFER_DONE rises
        if (!done_q) begin
          done_d  = 1'b1;
          beats_d = cnt_beats;
          xlast_d = rx_last_q;
          xovf_d  = cnt_ovf;
        end else if (XFER_ACK) begin
          state_d = IDLE;
          done_d  = 1'b0;
          beats_d = '0;
          xlast_d = 1'b0;
          xovf_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      ren_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      beats_q   <= '0;
      xlast_q   <= 1'b0;
      xovf_q    <= 1'b0;
      exp_q     <= '0;
      rx_last_q <= 1'b0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      ren_q     <= ren_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      beats_q   <= beats_d;
      xlast_q   <= xlast_d;
      xovf_q    <= xovf_d;
      exp_q     <= exp_d;
      rx_last_q <= rx_last_d;
      csum_q    <= csum_d;
    end
  end

  assign CHNL_RX_ACK      = ack_q;
  assign CHNL_RX_DATA_REN = ren_q;
  assign BRAM_WE          = we_q;
  assign BRAM_ADDR        = addr_q;
  assign BRAM_WDATA       = wdata_q;
  assign XFER_DONE        = done_q;
  assign XFER_BEATS       = beats_q;
  assign XFER_LAST        = xlast_q;
  assign XFER_OVERFLOW    = xovf_q;

`ifdef RX_CHECKSUM_EN
  assign XFER_CHECKSUM = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule
